// File: rtl/key_press_gen_pkg.sv
// Shared definitions for the key press emulator: clock period constants,
// FSM state encoding and the bounce LFSR seed, taps and step function.
package key_press_gen_pkg;

  localparam int CLK_FREQ_HZ      = 50_000_000;
  localparam int MS_PER_S         = 1000;
  localparam int DEFAULT_TICK_DIV = CLK_FREQ_HZ / MS_PER_S;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BNC_DN = 2'd1,
    ST_HOLD   = 2'd2,
    ST_BNC_UP = 2'd3
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {^(q & LFSR_TAPS), q[15:1]};
  endfunction

endpackage

// File: rtl/key_press_gen_lfsr16.sv
// 16-bit Fibonacci LFSR that supplies the contact-bounce levels; it only
// steps when enabled, so an idle emulator keeps its sequence position.
module lfsr16
  import key_press_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/key_press_gen.sv
// Emulates one press of an active-low push button: optional bounce on the
// falling edge, a timed stable-low hold, optional bounce on release.
module key_press_gen
  import key_press_gen_pkg::*;
#(
  parameter int TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int HOLD_WIDTH = 16,
  parameter int BOUNCE_EN  = 1,
  parameter int BOUNCE_MS  = 5,
  parameter int GLITCH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [HOLD_WIDTH-1:0] hold_ms,
  input  logic                  abort,
  output logic                  key_n,
  output logic                  busy,
  output logic                  done
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int GW   = (GLITCH_DIV > 1) ? $clog2(GLITCH_DIV) : 1;
  localparam int MS_W = (HOLD_WIDTH > 8) ? HOLD_WIDTH : 8;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PW-1:0]         r_presc;
  logic [MS_W-1:0]       r_ms;
  logic [GW-1:0]         r_gcnt;
  logic [HOLD_WIDTH-1:0] r_hold;
  logic                  r_key_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_key_n_d;
  logic                  w_busy_d;
  logic                  w_done_d;
  logic                  w_bounce;
  logic                  w_tick_last;
  logic                  w_phase_end;
  logic                  w_enter;
  logic                  w_strobe;
  logic [MS_W-1:0]       w_len;
  logic [15:0]           w_lfsr_q;
  logic                  w_lfsr_unused;

  assign w_bounce    = (r_state == ST_BNC_DN) || (r_state == ST_BNC_UP);
  assign w_tick_last = (r_presc == PW'(TICK_DIV - 1));
  assign w_len       = (r_state == ST_HOLD) ? MS_W'(r_hold) : MS_W'(BOUNCE_MS);
  // A zero-length hold ends on its first edge so the press still shows one busy cycle
  assign w_phase_end = (w_len == '0) || (w_tick_last && (r_ms == w_len - MS_W'(1)));
  assign w_enter     = (w_state_nxt != r_state);
  // The LFSR steps only when a bounce level is actually shown
  assign w_strobe    = w_bounce && !w_enter && (r_gcnt == GW'(GLITCH_DIV - 1));

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (w_strobe),
    .q   (w_lfsr_q)
  );

  assign w_lfsr_unused = ^w_lfsr_q[15:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_ms    <= '0;
      r_gcnt  <= '0;
      r_hold  <= '0;
      r_key_n <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key_n <= w_key_n_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      if ((r_state == ST_IDLE) && start) begin
        r_hold <= hold_ms;
      end
      if (w_enter || (r_state == ST_IDLE)) begin
        r_presc <= '0;
        r_ms    <= '0;
        r_gcnt  <= '0;
      end else begin
        if (w_tick_last) begin
          r_presc <= '0;
          r_ms    <= r_ms + MS_W'(1);
        end else begin
          r_presc <= r_presc + PW'(1);
        end
        r_gcnt <= (r_gcnt == GW'(GLITCH_DIV - 1)) ? '0 : r_gcnt + GW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = (BOUNCE_EN != 0) ? ST_BNC_DN : ST_HOLD;
      ST_BNC_DN: begin
        if (abort)            w_state_nxt = ST_IDLE;
        else if (w_phase_end) w_state_nxt = (r_hold == '0) ? ST_BNC_UP : ST_HOLD;
      end
      ST_HOLD: begin
        if (abort)            w_state_nxt = ST_IDLE;
        else if (w_phase_end) w_state_nxt = (BOUNCE_EN != 0) ? ST_BNC_UP : ST_IDLE;
      end
      ST_BNC_UP: begin
        if (abort || w_phase_end) w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_key_n_d = r_key_n;
    w_done_d  = 1'b0;
    w_busy_d  = (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_IDLE: begin
        w_key_n_d = 1'b1;
        w_done_d  = (r_state != ST_IDLE) && !abort;
      end
      ST_BNC_DN: begin
        if (w_enter)       w_key_n_d = 1'b0;
        else if (w_strobe) w_key_n_d = w_lfsr_q[0];
      end
      ST_HOLD: begin
        // Entered straight from IDLE with a zero hold: the line never drops
        if (w_enter) w_key_n_d = (r_state == ST_IDLE) && (hold_ms == '0);
      end
      ST_BNC_UP: begin
        if (w_enter)       w_key_n_d = 1'b1;
        else if (w_strobe) w_key_n_d = w_lfsr_q[0];
      end
      default:   w_key_n_d = 1'b1;
    endcase
  end

  assign key_n = r_key_n;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen: a clean-press and a bouncing instance share the
// stimulus; each is checked every cycle against a waveform-list model.
module tb_key_press_gen;

  localparam int TD   = 4;
  localparam int GD   = 1;
  localparam int BMS  = 2;
  localparam int HW   = 16;
  localparam int BL   = BMS * TD;
  localparam int MAXL = 512;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [HW-1:0] hold_ms;
  logic          key0, busy0, done0;
  logic          key1, busy1, done1;

  int total = 0;
  int bad   = 0;

  key_press_gen #(.TICK_DIV(TD), .HOLD_WIDTH(HW), .BOUNCE_EN(0), .BOUNCE_MS(BMS), .GLITCH_DIV(GD)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .hold_ms(hold_ms), .abort(abort),
    .key_n(key0), .busy(busy0), .done(done0)
  );

  key_press_gen #(.TICK_DIV(TD), .HOLD_WIDTH(HW), .BOUNCE_EN(1), .BOUNCE_MS(BMS), .GLITCH_DIV(GD)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .hold_ms(hold_ms), .abort(abort),
    .key_n(key1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index 0 = clean press, 1 = bouncing press. A press is a list of
  // per-cycle line codes: 0/1 fixed level, 2 fresh random level, 3 keep level.
  int          seq [2][MAXL];
  int          len [2];
  int          rd [2];
  bit          active [2];
  logic        ekey [2];
  logic        ebusy [2];
  logic        edone [2];
  logic [15:0] lf [2];

  int   nbusy [2];
  int   nlow [2];
  int   ndone [2];
  int   ncap;
  logic cap_dut [8];
  logic cap_mod [8];
  logic [7:0] bnc_ref;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  task automatic push(input int i, input int c);
    seq[i][len[i]] = c;
    len[i]++;
  endtask

  task automatic push_bounce(input int i, input int first);
    push(i, first);
    for (int k = 1; k < BL; k++) push(i, (k % GD == 0) ? 2 : 3);
  endtask

  task automatic build(input int i, input int h);
    len[i] = 0;
    rd[i]  = 0;
    if (i == 1) begin
      push_bounce(i, 0);
      for (int k = 0; k < h * TD; k++) push(i, 0);
      push_bounce(i, 1);
    end else if (h == 0) begin
      push(i, 1);
    end else begin
      for (int k = 0; k < h * TD; k++) push(i, 0);
    end
  endtask

  task automatic take(input int i);
    int c;
    c = seq[i][rd[i]];
    rd[i]++;
    if (c == 2) begin
      ekey[i] = lf[i][0];
      lf[i]   = lfsr_step(lf[i]);
    end else if (c != 3) begin
      ekey[i] = (c == 1);
    end
    ebusy[i] = 1'b1;
    edone[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    if (rst) begin
      active[i] = 1'b0; len[i] = 0; rd[i] = 0;
      ekey[i] = 1'b1; ebusy[i] = 1'b0; edone[i] = 1'b0; lf[i] = 16'hACE1;
    end else if (!active[i]) begin
      edone[i] = 1'b0;
      if (start) begin
        build(i, int'(hold_ms));
        active[i] = 1'b1;
        take(i);
      end else begin
        ekey[i] = 1'b1; ebusy[i] = 1'b0;
      end
    end else if (abort) begin
      active[i] = 1'b0; ekey[i] = 1'b1; ebusy[i] = 1'b0; edone[i] = 1'b0;
    end else if (rd[i] == len[i]) begin
      active[i] = 1'b0; ekey[i] = 1'b1; ebusy[i] = 1'b0; edone[i] = 1'b1;
    end else begin
      take(i);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      nbusy[i] = 0; nlow[i] = 0; ndone[i] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("key_n0", key0, ekey[0]);
    chk("busy0", busy0, ebusy[0]);
    chk("done0", done0, edone[0]);
    chk("key_n1", key1, ekey[1]);
    chk("busy1", busy1, ebusy[1]);
    chk("done1", done1, edone[1]);
    if (busy0) nbusy[0]++;
    if (!key0) nlow[0]++;
    if (done0) ndone[0]++;
    if (busy1) nbusy[1]++;
    if (!key1) nlow[1]++;
    if (done1) ndone[1]++;
    if (ncap < 8) begin
      cap_dut[ncap] = key1;
      cap_mod[ncap] = ekey[1];
      ncap++;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy0 || busy1 || active[0] || active[1]) && n < 300) begin
      cycle();
      n++;
    end
    chk({nm, "_settle"}, 32'(n < 300), 32'd1);
  endtask

  task automatic run_press(input int h, input string nm);
    clear_stats();
    ncap    = 0;
    hold_ms = HW'(h);
    start   = 1'b1;
    cycle();
    start   = 1'b0;
    hold_ms = HW'($urandom_range(0, 9));
    wait_idle(nm);
  endtask

  task automatic chk_bounce(input string nm);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_dut%0d", nm, k), cap_dut[k], bnc_ref[k]);
      chk($sformatf("%s_model%0d", nm, k), cap_mod[k], bnc_ref[k]);
    end
  endtask

  initial begin
    // Falling-bounce levels of the first press after reset, seed ACE1: 0,1,0,0,0,0,1,1
    bnc_ref = 8'hC2;
    ncap    = 8;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    hold_ms = '0;
    clear_stats();
    repeat (2) cycle();
    chk("rst_key_n", key0 & key1, 32'd1);
    chk("rst_busy", busy0 | busy1, 32'd0);
    chk("rst_done", done0 | done1, 32'd0);
    rst = 1'b0;
    cycle();

    run_press(3, "p3");
    chk("p3_busy0", nbusy[0], 12);
    chk("p3_low0", nlow[0], 12);
    chk("p3_done0", ndone[0], 1);
    chk("p3_busy1", nbusy[1], 28);
    chk("p3_done1", ndone[1], 1);
    chk_bounce("p3_bnc");

    run_press(5, "p5");
    chk("p5_busy0", nbusy[0], 20);
    chk("p5_low0", nlow[0], 20);
    chk("p5_busy1", nbusy[1], 36);
    chk("p5_done1", ndone[1], 1);

    clear_stats();
    hold_ms = 16'd5;
    start   = 1'b1;
    cycle();
    start   = 1'b0;
    repeat (4) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_key_n0", key0, 1);
    chk("abort_busy0", busy0, 0);
    chk("abort_busy1", busy1, 0);
    cycle();
    chk("abort_done0", ndone[0], 0);
    chk("abort_done1", ndone[1], 0);
    run_press(2, "after_abort");
    chk("after_abort_busy0", nbusy[0], 8);
    chk("after_abort_done0", ndone[0], 1);

    clear_stats();
    hold_ms = 16'd3;
    start   = 1'b1;
    cycle();
    for (int k = 0; k < 10; k++) begin
      start   = 1'b1;
      hold_ms = HW'($urandom_range(4, 40));
      cycle();
    end
    start = 1'b0;
    wait_idle("restart");
    chk("restart_busy0", nbusy[0], 12);
    chk("restart_done0", ndone[0], 1);
    chk("restart_busy1", nbusy[1], 28);
    chk("restart_done1", ndone[1], 1);

    hold_ms = 16'd6;
    start   = 1'b1;
    cycle();
    start = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    #1;
    chk("async_key_n0", key0, 1);
    chk("async_key_n1", key1, 1);
    chk("async_busy", busy0 | busy1, 0);
    cycle();
    rst = 1'b0;
    clear_stats();
    repeat (2) cycle();
    chk("rst_release_done", ndone[0] + ndone[1], 0);
    run_press(3, "post_rst");
    chk("post_rst_busy0", nbusy[0], 12);
    chk("post_rst_busy1", nbusy[1], 28);
    chk_bounce("post_rst_bnc");

    run_press(0, "h0");
    chk("h0_busy0", nbusy[0], 1);
    chk("h0_low0", nlow[0], 0);
    chk("h0_done0", ndone[0], 1);
    chk("h0_busy1", nbusy[1], 16);
    chk("h0_done1", ndone[1], 1);

    hold_ms = 16'd2;
    start   = 1'b1;
    abort   = 1'b1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy0", busy0, 1);
    chk("start_abort_busy1", busy1, 1);
    wait_idle("start_abort");

    clear_stats();
    hold_ms = 16'd1;
    start   = 1'b1;
    repeat (20) cycle();
    start = 1'b0;
    wait_idle("held_start");
    chk("held_start_done0", ndone[0], 4);
    chk("held_start_done1", ndone[1], 1);

    for (int k = 0; k < 600; k++) begin
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 29) == 0);
      hold_ms = HW'($urandom_range(0, 6));
      cycle();
    end
    start = 1'b0;
    abort = 1'b0;
    wait_idle("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_press_gen.md
KEY_PRESS_GEN -- requirements
Module: key_press_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clock cycles per millisecond tick, minimum 2.
REQ-002 SHALL have parameter HOLD_WIDTH, default 16, width of the requested hold time in ms.
REQ-003 SHALL have parameter BOUNCE_EN, default 1; 1 emulates contact bounce, 0 gives a clean press.
REQ-004 SHALL have parameter BOUNCE_MS, default 5, bounce phase length in ms; 1..255.
REQ-005 SHALL have parameter GLITCH_DIV, default 1000, clock cycles between bounce level updates, minimum 1.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-008 start  input  1  request one press; sampled only when busy=0.
REQ-009 hold_ms  input  HOLD_WIDTH  stable low time of the press in ms; latched with start.
REQ-010 abort  input  1  cancel the press in progress.
REQ-011 key_n  output  1  emulated active-low key line; registered.
REQ-012 busy  output  1  high from press acceptance until completion or abort.
REQ-013 done  output  1  one-cycle pulse at normal completion.

Function
REQ-014 SHALL implement states IDLE, BNC_DN, HOLD, BNC_UP; all outputs SHALL be registered.
REQ-015 IDLE: key_n=1, busy=0. The edge sampling start=1 SHALL latch hold_ms, set busy=1, and enter BNC_DN (BOUNCE_EN=1) or HOLD (BOUNCE_EN=0).
REQ-016 Time base: prescaler 0..TICK_DIV-1 and ms counter SHALL both clear on every state entry; a phase of N ms SHALL last exactly N*TICK_DIV cycles.
REQ-017 BNC_DN: lasts BOUNCE_MS ms; key_n=0 on entry, then key_n = lfsr[0] updated every GLITCH_DIV cycles; next state HOLD.
REQ-018 HOLD: key_n=0 for exactly latched hold_ms*TICK_DIV cycles; next state BNC_UP (BOUNCE_EN=1) or IDLE.
REQ-019 BNC_UP: lasts BOUNCE_MS ms; key_n=1 on entry, then key_n = lfsr[0] updated every GLITCH_DIV cycles; next state IDLE.
REQ-020 Return to IDLE from a normal phase end SHALL drive key_n=1, busy=0, and done=1 for exactly one cycle on the same edge.
REQ-021 hold_ms=0 SHALL skip HOLD; with BOUNCE_EN=0 the sequence is: start edge -> busy=1 one cycle, key_n stays 1 -> done pulse next edge.
REQ-022 start while busy=1 SHALL be ignored and SHALL NOT re-latch hold_ms.
REQ-023 abort=1 in any non-IDLE state SHALL return to IDLE on that edge: key_n=1, busy=0, done=0; abort has priority over phase end.
REQ-024 abort and start together in IDLE: start accepted, abort ignored.
REQ-025 start on the same edge done pulses SHALL NOT be accepted (busy still 1); earliest acceptance is the following edge.
REQ-026 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1; advances only on GLITCH_DIV strobes inside BNC_DN/BNC_UP; never all-zero.
REQ-027 hold_ms max (2^HOLD_WIDTH-1) SHALL be supported; ms counter HOLD_WIDTH bits, no wrap-around.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, key_n=1, busy=0, done=0, prescaler=0, ms counter=0, LFSR=16'hACE1, latched hold=0.
REQ-029 Reset mid-press SHALL release key_n high immediately; no done pulse on reset release.

Structure
REQ-030 Shared package key_press_gen_pkg SHALL hold the state encoding, LFSR seed and tap constants.
REQ-031 The LFSR SHALL be a sub-module named lfsr16 with clk, rst, en, q[15:0].
REQ-032 The ms time base SHALL reuse the codebase global period constants for the default TICK_DIV.

Verification (TICK_DIV=4, GLITCH_DIV=1, BOUNCE_MS=2)
REQ-033 BOUNCE_EN=0, start with hold_ms=3 -> key_n low exactly 12 cycles, done one cycle at key_n rise, busy 12 cycles.
REQ-034 BOUNCE_EN=1, hold_ms=5 -> 8 bounce cycles from 0, 20 cycles stable 0, 8 bounce cycles from 1, then key_n=1 with done; busy 36 cycles; bounce levels match LFSR model from seed ACE1.
REQ-035 abort in HOLD cycle 5 -> key_n=1 and busy=0 next edge, no done; subsequent start accepted normally.
REQ-036 start pulsed repeatedly with hold_ms changing during a press -> single press, original duration, one done.
REQ-037 rst asserted mid-HOLD -> key_n=1 asynchronously; after release LFSR restarts at ACE1 and next press is identical to a first press.
REQ-038 hold_ms=0 with BOUNCE_EN=0 -> key_n never low, busy one cycle, done next edge.
